// File: rtl/mem_1r1w_masked_48x64_ctrl.sv
// mem_1r1w_masked_48x64_ctrl
//   Front-end controller for the mem_1r1w_masked_48x64 macro. After reset it
//   zero-fills every entry, then round-robin arbitrates two masked write
//   requesters onto W0 and serves one read requester on R0, buffering read
//   data in a 2-entry FIFO behind a valid/ready response channel.
// Ports
//   clock, reset_n                 : single clock, synchronous active-low reset
//   init_done                      : high once zero-initialisation has finished
//   wa_* / wb_*                    : write requesters A/B (valid/ready + addr/data/mask)
//   rd_req_*                       : read request channel (valid/ready + addr)
//   rd_resp_*                      : read response channel (valid/ready + data)
//   W0_en/W0_addr/W0_data/W0_mask  : memory write port
//   R0_en/R0_addr/R0_data          : memory read port, data one cycle after R0_en
module mem_1r1w_masked_48x64_ctrl #(
  parameter int unsigned DEPTH  = 48,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              wa_valid,
  output logic              wa_ready,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic [MASK_W-1:0] wa_mask,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [MASK_W-1:0] wb_mask,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              W0_en,
  output logic [ADDR_W-1:0] W0_addr,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask,
  output logic              R0_en,
  output logic [ADDR_W-1:0] R0_addr,
  input  logic [DATA_W-1:0] R0_data
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;            // 0: A has priority, 1: B has priority
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              grant_a, grant_b;
  logic              pop, push, collide, accept;
  logic [2:0]        credit;

  // Initialisation sequencing and write arbitration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    W0_en    = 1'b0;
    W0_addr  = cnt_q;
    W0_data  = '0;
    W0_mask  = '1;
    case (state_q)
      ST_INIT: begin
        // Held off while reset is still asserted so the macro sees no writes
        // until the zero-fill actually starts.
        W0_en = reset_n;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        grant_a = wa_valid & (~wb_valid | ~rr_q);
        grant_b = wb_valid & ~grant_a;
        if (grant_a) begin
          W0_en   = 1'b1;
          W0_addr = wa_addr;
          W0_data = wa_data;
          W0_mask = wa_mask;
          rr_d    = 1'b1;
        end else if (grant_b) begin
          W0_en   = 1'b1;
          W0_addr = wb_addr;
          W0_data = wb_data;
          W0_mask = wb_mask;
          rr_d    = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    init_done = (state_q == ST_RUN);
    wa_ready  = grant_a;
    wb_ready  = grant_b;
  end

  // Read path: credit counts the read in flight plus buffered responses, net
  // of a pop this cycle, so at most two results are ever owed to the FIFO.
  always_comb begin
    pop          = (count_q != 2'd0) & rd_resp_ready;
    credit       = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    collide      = W0_en & (W0_addr == rd_req_addr);
    rd_req_ready = (state_q == ST_RUN) & (credit < 3'd2) & ~collide;
    accept       = rd_req_valid & rd_req_ready;
    R0_en        = accept;
    R0_addr      = rd_req_addr;
    inflight_d   = accept;
    push         = inflight_q;
    fifo_d       = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = R0_data;
    end
    wr_ptr_d      = wr_ptr_q ^ push;
    rd_ptr_d      = rd_ptr_q ^ pop;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    rd_resp_valid = (count_q != 2'd0);
    rd_resp_data  = fifo_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_masked_48x64_ctrl.sv
// Bench for mem_1r1w_masked_48x64_ctrl with a behavioural masked memory on
// W0/R0, a shadow copy of expected contents and a read-response scoreboard.
module tb_mem_1r1w_masked_48x64_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        init_done;
  logic        wa_valid, wa_ready, wb_valid, wb_ready;
  logic [5:0]  wa_addr, wb_addr;
  logic [63:0] wa_data, wb_data;
  logic [7:0]  wa_mask, wb_mask;
  logic        rd_req_valid, rd_req_ready;
  logic [5:0]  rd_req_addr;
  logic        rd_resp_valid, rd_resp_ready;
  logic [63:0] rd_resp_data;
  logic        W0_en;
  logic [5:0]  W0_addr;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;
  logic        R0_en;
  logic [5:0]  R0_addr;
  logic [63:0] R0_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  mem_1r1w_masked_48x64_ctrl #(
    .DEPTH (48),
    .ADDR_W(6),
    .DATA_W(64),
    .MASK_W(8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .init_done    (init_done),
    .wa_valid     (wa_valid),
    .wa_ready     (wa_ready),
    .wa_addr      (wa_addr),
    .wa_data      (wa_data),
    .wa_mask      (wa_mask),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_mask      (wb_mask),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_resp_data (rd_resp_data),
    .W0_en        (W0_en),
    .W0_addr      (W0_addr),
    .W0_data      (W0_data),
    .W0_mask      (W0_mask),
    .R0_en        (R0_en),
    .R0_addr      (R0_addr),
    .R0_data      (R0_data)
  );

  // Behavioural memory macro; starts with garbage so the zero-fill is visible.
  logic [63:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
  end
  always @(posedge clock) begin
    if (R0_en) R0_data <= mem[R0_addr];
    if (W0_en) begin
      for (int b = 0; b < 8; b++)
        if (W0_mask[b]) mem[W0_addr][8*b +: 8] <= W0_data[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected data pushed on read accept, popped on response.
  logic [63:0] shadow [64];
  logic [63:0] exp_q [$];
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      for (int i = 0; i < 64; i++) shadow[i] = '0;
    end else begin
      if (rd_resp_valid && rd_resp_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_resp", 64'd1, 64'd0);
        else check("sb_resp_data", rd_resp_data, exp_q.pop_front());
      end
      if (rd_req_valid && rd_req_ready) exp_q.push_back(shadow[rd_req_addr]);
      if (wa_valid && wa_ready)
        for (int b = 0; b < 8; b++) if (wa_mask[b]) shadow[wa_addr][8*b +: 8] = wa_data[8*b +: 8];
      if (wb_valid && wb_ready)
        for (int b = 0; b < 8; b++) if (wb_mask[b]) shadow[wb_addr][8*b +: 8] = wb_data[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [63:0] d);
    bit acc, got;
    acc = 1'b0;
    got = 1'b0;
    d   = '0;
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clock);
      acc = rd_req_ready;
      step();
    end
    rd_req_valid = 1'b0;
    check("rd_accept", 64'(acc), 64'd1);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if (rd_resp_valid) begin
        got = 1'b1;
        d   = rd_resp_data;
      end
      step();
    end
    check("rd_resp_seen", 64'(got), 64'd1);
  endtask

  typedef struct {
    bit wa_v;
    bit wb_v;
    bit exp_a;
    bit exp_b;
  } arb_vec_t;

  arb_vec_t    vecs [11];
  logic [63:0] rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 1, 1, 0};
    vecs[1]  = '{1, 1, 0, 1};
    vecs[2]  = '{1, 1, 1, 0};
    vecs[3]  = '{1, 1, 0, 1};
    vecs[4]  = '{0, 1, 0, 1};
    vecs[5]  = '{0, 1, 0, 1};
    vecs[6]  = '{0, 1, 0, 1};
    vecs[7]  = '{1, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0};
    vecs[9]  = '{1, 1, 0, 1};
    vecs[10] = '{1, 1, 1, 0};

    reset_n = 1'b0;
    wa_valid = 1'b1; wb_valid = 1'b1; rd_req_valid = 1'b1;
    wa_addr = 6'd1; wb_addr = 6'd2; rd_req_addr = 6'd3;
    wa_data = '1; wb_data = '1; wa_mask = '1; wb_mask = '1;
    rd_resp_ready = 1'b1;
    repeat (3) step();

    // Reset state
    @(negedge clock);
    check("rst_init_done", 64'(init_done), 0);
    check("rst_wa_ready", 64'(wa_ready), 0);
    check("rst_wb_ready", 64'(wb_ready), 0);
    check("rst_rd_req_ready", 64'(rd_req_ready), 0);
    check("rst_rd_resp_valid", 64'(rd_resp_valid), 0);
    check("rst_W0_en", 64'(W0_en), 0);
    check("rst_R0_en", 64'(R0_en), 0);
    step();

    // Zero-fill sequence
    reset_n = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      check("init_W0_en", 64'(W0_en), 1);
      check("init_W0_addr", 64'(W0_addr), 64'(i));
      check("init_W0_mask", 64'(W0_mask), 64'hFF);
      check("init_W0_data", W0_data, 0);
      check("init_done_low", 64'(init_done), 0);
      check("init_ready_low", 64'({wa_ready, wb_ready, rd_req_ready, R0_en}), 0);
      step();
    end
    wa_valid = 1'b0; wb_valid = 1'b0; rd_req_valid = 1'b0;
    @(negedge clock);
    check("init_done_high", 64'(init_done), 1);
    check("run_W0_idle", 64'(W0_en), 0);
    step();

    // Round-robin arbitration table
    for (int i = 0; i < 11; i++) begin
      wa_valid = vecs[i].wa_v;
      wb_valid = vecs[i].wb_v;
      wa_addr  = 6'(10 + i);
      wb_addr  = 6'(30 + i);
      wa_data  = 64'hA000_0000_0000_0000 + 64'(i);
      wb_data  = 64'hB000_0000_0000_0000 + 64'(i);
      wa_mask  = 8'hFF;
      wb_mask  = 8'hFF;
      @(negedge clock);
      check("arb_wa_ready", 64'(wa_ready), 64'(vecs[i].exp_a));
      check("arb_wb_ready", 64'(wb_ready), 64'(vecs[i].exp_b));
      check("arb_W0_en", 64'(W0_en), 64'(vecs[i].exp_a | vecs[i].exp_b));
      if (vecs[i].exp_a) check("arb_W0_addr_a", 64'(W0_addr), 64'(10 + i));
      if (vecs[i].exp_b) check("arb_W0_addr_b", 64'(W0_addr), 64'(30 + i));
      if (vecs[i].exp_b) check("arb_W0_data_b", W0_data, 64'hB000_0000_0000_0000 + 64'(i));
      step();
    end
    wa_valid = 1'b0; wb_valid = 1'b0;

    // Masked write merge
    wa_valid = 1'b1; wa_addr = 6'd5; wa_data = 64'h1122334455667788; wa_mask = 8'hFF;
    step();
    wa_data = 64'hAAAAAAAAAAAAAAAA; wa_mask = 8'h0F;
    @(negedge clock);
    check("mask_W0_mask", 64'(W0_mask), 64'h0F);
    step();
    wa_valid = 1'b0;
    do_read(6'd5, rdata);
    check("mask_merge_data", rdata, 64'h11223344AAAAAAAA);

    // Write/read collision on the same address
    wa_valid = 1'b1; wa_addr = 6'd9; wa_data = 64'h0909_1234_5678_9A9A; wa_mask = 8'hFF;
    rd_req_valid = 1'b1; rd_req_addr = 6'd9;
    @(negedge clock);
    check("collide_wa_ready", 64'(wa_ready), 1);
    check("collide_blocked", 64'(rd_req_ready), 0);
    step();
    wa_valid = 1'b0;
    @(negedge clock);
    check("collide_retry", 64'(rd_req_ready), 1);
    step();
    rd_req_valid = 1'b0;
    @(negedge clock);
    check("lat_cycle1_valid", 64'(rd_resp_valid), 0);
    step();
    @(negedge clock);
    check("lat_cycle2_valid", 64'(rd_resp_valid), 1);
    check("collide_new_data", rd_resp_data, 64'h0909_1234_5678_9A9A);
    step();
    // Different addresses in the same cycle do not block the read
    wa_valid = 1'b1; wa_addr = 6'd10; wa_data = 64'h1010; rd_req_valid = 1'b1; rd_req_addr = 6'd11;
    @(negedge clock);
    check("no_collide_ready", 64'(rd_req_ready), 1);
    step();
    wa_valid = 1'b0; rd_req_valid = 1'b0;
    repeat (4) step();

    // Backpressure: two reads accepted, the third stalls
    rd_resp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 6'd5;
    @(negedge clock); check("bp_accept1", 64'(rd_req_ready), 1); step();
    rd_req_addr = 6'd9;
    @(negedge clock); check("bp_accept2", 64'(rd_req_ready), 1); step();
    rd_req_addr = 6'd20;
    @(negedge clock); check("bp_stall3", 64'(rd_req_ready), 0); step();
    @(negedge clock);
    check("bp_stall3_again", 64'(rd_req_ready), 0);
    check("bp_head_valid", 64'(rd_resp_valid), 1);
    check("bp_head_stable", rd_resp_data, 64'h11223344AAAAAAAA);
    step();
    rd_resp_ready = 1'b1;
    @(negedge clock); check("bp_release_accept", 64'(rd_req_ready), 1); step();
    rd_req_valid = 1'b0;
    repeat (5) step();
    check("bp_drained", 64'(exp_q.size()), 0);

    // Reset with a read in flight and one buffered response
    rd_resp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 6'd5;
    step();
    rd_req_addr = 6'd9;
    step();
    rd_req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check("pre_reset_fifo_valid", 64'(rd_resp_valid), 1);
    step();
    @(negedge clock);
    check("reset_flush_valid", 64'(rd_resp_valid), 0);
    check("reset_W0_en", 64'(W0_en), 0);
    check("reset_init_done", 64'(init_done), 0);
    step();
    reset_n = 1'b1;
    rd_resp_ready = 1'b1;
    @(negedge clock);
    check("reinit_W0_en", 64'(W0_en), 1);
    check("reinit_W0_addr", 64'(W0_addr), 0);
    check("reinit_no_resp", 64'(rd_resp_valid), 0);
    repeat (48) step();
    @(negedge clock);
    check("reinit_done", 64'(init_done), 1);
    step();
    do_read(6'd5, rdata);
    check("reinit_zero_data", rdata, 64'd0);
    repeat (3) step();
    check("sb_empty_at_end", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
